// File: rtl/memmap_pkg.sv
// Shared constants for the 68k address decoder / wait-state generator:
// chip-select bit positions, top-byte region boundaries and FSM states.
package memmap_pkg;

  localparam int CS_CTRL  = 7;
  localparam int CS_GFX   = 6;
  localparam int CS_IO    = 5;
  localparam int CS_PGTBL = 4;
  localparam int CS_RAM1  = 3;
  localparam int CS_RAM2  = 2;
  localparam int CS_ROM   = 1;
  localparam int CS_UNMAP = 0;

  localparam logic [7:0] T_UNMAP   = 8'h00;
  localparam logic [7:0] T_CTRL    = 8'h01;
  localparam logic [7:0] T_PGTBL   = 8'h02;
  localparam logic [7:0] T_IO      = 8'h03;
  localparam logic [7:0] T_GFX_LO  = 8'h3C;
  localparam logic [7:0] T_OVL_HI  = 8'h3F;
  localparam logic [7:0] T_ROM_LO  = 8'h40;
  localparam logic [7:0] T_RAM1_LO = 8'h80;
  localparam logic [7:0] T_RAM2_LO = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_TOUT = 3'd3,
    ST_BERR = 3'd4
  } state_e;

endpackage

// File: rtl/memmap_decode.sv
// Combinational top-byte decoder: one-hot chip select, region wait states,
// and an undefined-region flag. Boot overlay redirects low reads to ROM.
module memmap_decode
  import memmap_pkg::*;
#(
  parameter int WS_CTRL  = 0,
  parameter int WS_PGTBL = 0,
  parameter int WS_IO    = 3,
  parameter int WS_GFX   = 1,
  parameter int WS_ROM   = 2,
  parameter int WS_RAM   = 0,
  parameter int WS_UNMAP = 0
) (
  input  logic [7:0] top_i,
  input  logic       rw_i,
  input  logic       overlay_i,
  output logic [7:0] cs_o,
  output logic [3:0] ws_o,
  output logic       undef_o
);

  always_comb begin
    cs_o    = 8'd0;
    ws_o    = 4'd0;
    undef_o = 1'b0;
    if (overlay_i && rw_i && (top_i <= T_OVL_HI)) begin
      cs_o[CS_ROM] = 1'b1;
      ws_o         = 4'(WS_ROM);
    end else if (top_i == T_UNMAP) begin
      cs_o[CS_UNMAP] = 1'b1;
      ws_o           = 4'(WS_UNMAP);
    end else if (top_i == T_CTRL) begin
      cs_o[CS_CTRL] = 1'b1;
      ws_o          = 4'(WS_CTRL);
    end else if (top_i == T_PGTBL) begin
      cs_o[CS_PGTBL] = 1'b1;
      ws_o           = 4'(WS_PGTBL);
    end else if (top_i == T_IO) begin
      cs_o[CS_IO] = 1'b1;
      ws_o        = 4'(WS_IO);
    end else if (top_i >= T_RAM2_LO) begin
      cs_o[CS_RAM2] = 1'b1;
      ws_o          = 4'(WS_RAM);
    end else if (top_i >= T_RAM1_LO) begin
      cs_o[CS_RAM1] = 1'b1;
      ws_o          = 4'(WS_RAM);
    end else if (top_i >= T_ROM_LO) begin
      cs_o[CS_ROM] = 1'b1;
      ws_o         = 4'(WS_ROM);
    end else if (top_i >= T_GFX_LO) begin
      cs_o[CS_GFX] = 1'b1;
      ws_o         = 4'(WS_GFX);
    end else begin
      // 04..3B: no slave responds; the FSM times out into a bus error
      undef_o = 1'b1;
    end
  end

endmodule

// File: rtl/memmap_ws.sv
// Registered 68k bus-cycle decoder: drives chip selects, counts wait states,
// returns dtack, or raises berr after a timeout for undefined regions.
module memmap_ws
  import memmap_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int WS_CTRL      = 0,
  parameter int WS_PGTBL     = 0,
  parameter int WS_IO        = 3,
  parameter int WS_GFX       = 1,
  parameter int WS_ROM       = 2,
  parameter int WS_RAM       = 0,
  parameter int WS_UNMAP     = 0,
  parameter int BERR_TIMEOUT = 16,
  parameter int BOOT_FETCHES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              as,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [7:0]        cs,
  output logic              dtack,
  output logic              berr
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cs_q, cs_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic [3:0] boot_q, boot_d;
  logic       ovl_q, ovl_d;

  logic [7:0] top_s;
  logic [7:0] dec_cs_s;
  logic [3:0] dec_ws_s;
  logic       dec_undef_s;
  logic       overlay_s;
  logic       ovl_hit_s;

  assign top_s     = addr_in[ADDR_W-1 -: 8];
  assign overlay_s = (boot_q != 4'd0);
  assign ovl_hit_s = overlay_s && rw && (top_s <= T_OVL_HI);

  memmap_decode #(
    .WS_CTRL (WS_CTRL),
    .WS_PGTBL(WS_PGTBL),
    .WS_IO   (WS_IO),
    .WS_GFX  (WS_GFX),
    .WS_ROM  (WS_ROM),
    .WS_RAM  (WS_RAM),
    .WS_UNMAP(WS_UNMAP)
  ) u_decode (
    .top_i    (top_s),
    .rw_i     (rw),
    .overlay_i(overlay_s),
    .cs_o     (dec_cs_s),
    .ws_o     (dec_ws_s),
    .undef_o  (dec_undef_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    boot_d  = boot_q;
    ovl_d   = ovl_q;
    case (state_q)
      ST_IDLE: begin
        if (as) begin
          if (dec_undef_s) begin
            cs_d    = 8'd0;
            cnt_d   = 8'(BERR_TIMEOUT - 1);
            ovl_d   = 1'b0;
            state_d = ST_TOUT;
          end else begin
            cs_d    = dec_cs_s;
            cnt_d   = {4'd0, dec_ws_s};
            ovl_d   = ovl_hit_s;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!as) begin
          cs_d    = 8'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          dtack_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        if (!as) begin
          cs_d    = 8'd0;
          dtack_d = 1'b0;
          state_d = ST_IDLE;
          // only a completed overlay read consumes a boot fetch
          if (ovl_q && (boot_q != 4'd0)) begin
            boot_d = boot_q - 4'd1;
          end else begin
            boot_d = boot_q;
          end
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_TOUT: begin
        if (!as) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          berr_d  = 1'b1;
          state_d = ST_BERR;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_BERR: begin
        if (!as) begin
          berr_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BERR;
        end
      end
      default: begin
        cs_d    = 8'd0;
        dtack_d = 1'b0;
        berr_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      cs_q    <= 8'd0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      boot_q  <= 4'(BOOT_FETCHES);
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      boot_q  <= boot_d;
      ovl_q   <= ovl_d;
    end
  end

  assign cs    = cs_q;
  assign dtack = dtack_q;
  assign berr  = berr_q;

endmodule

// File: tb/tb_memmap_ws.sv
// Self-checking bench for memmap_ws: directed bus cycles then random ones,
// each checked edge by edge against a region-table reference model.
module tb_memmap_ws;

  localparam int ADDR_W = 8;
  localparam int BT     = 16;
  localparam int BOOT   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bus_as = 1'b0;
  logic              bus_rw = 1'b1;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [7:0]        cs;
  logic              dtack;
  logic              berr;

  int n_cmp = 0;
  int n_mis = 0;
  int m_boot = BOOT;

  always #5 clk = ~clk;

  memmap_ws #(
    .ADDR_W(ADDR_W), .WS_CTRL(0), .WS_PGTBL(0), .WS_IO(3), .WS_GFX(1),
    .WS_ROM(2), .WS_RAM(0), .WS_UNMAP(0), .BERR_TIMEOUT(BT), .BOOT_FETCHES(BOOT)
  ) dut (
    .clk(clk), .rst(rst), .as(bus_as), .rw(bus_rw), .addr_in(bus_addr),
    .cs(cs), .dtack(dtack), .berr(berr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] ecs, input logic ed, input logic eb);
    check({tag, ".cs"}, {24'd0, cs}, {24'd0, ecs});
    check({tag, ".dtack"}, {31'd0, dtack}, {31'd0, ed});
    check({tag, ".berr"}, {31'd0, berr}, {31'd0, eb});
  endtask

  // Address map as a table of top-byte ranges, independent of the decoder structure.
  function automatic void model(input logic [7:0] t, input bit rd, input int boot,
                                output logic [7:0] c, output int ws,
                                output bit undef, output bit ovl);
    ovl   = (boot > 0) && rd && (t <= 8'h3F);
    undef = 1'b0;
    ws    = 0;
    if (ovl)              begin c = 8'h02; ws = 2; end
    else if (t == 8'h00)  begin c = 8'h01; ws = 0; end
    else if (t == 8'h01)  begin c = 8'h80; ws = 0; end
    else if (t == 8'h02)  begin c = 8'h10; ws = 0; end
    else if (t == 8'h03)  begin c = 8'h20; ws = 3; end
    else if (t <  8'h3C)  begin c = 8'h00; undef = 1'b1; end
    else if (t <  8'h40)  begin c = 8'h40; ws = 1; end
    else if (t <  8'h80)  begin c = 8'h02; ws = 2; end
    else if (t <  8'hC0)  begin c = 8'h08; ws = 0; end
    else                  begin c = 8'h04; ws = 0; end
  endfunction

  // One bus cycle; abort_at = 0 runs to completion, else as drops before edge N+abort_at.
  task automatic bus_cycle(input logic [7:0] t, input bit rd, input int abort_at, input int hold);
    logic [7:0] ecs;
    int ws, lat;
    bit undef, ovl;
    string tag;
    model(t, rd, m_boot, ecs, ws, undef, ovl);
    lat = undef ? BT : 1 + ws;
    tag = $sformatf("%s%02h", rd ? "rd" : "wr", t);
    bus_as = 1'b1; bus_rw = rd; bus_addr = t;
    tick();
    check_out({tag, ".start"}, ecs, 1'b0, 1'b0);
    if (abort_at > 0) begin
      for (int e = 1; e < abort_at; e++) begin
        tick();
        check_out({tag, ".wait"}, ecs, 1'b0, 1'b0);
      end
      bus_as = 1'b0;
      tick();
      check_out({tag, ".abort"}, 8'h00, 1'b0, 1'b0);
    end else begin
      for (int e = 1; e < lat; e++) begin
        tick();
        check_out({tag, ".wait"}, ecs, 1'b0, 1'b0);
      end
      for (int e = 0; e <= hold; e++) begin
        tick();
        check_out({tag, ".done"}, ecs, !undef, undef);
      end
      bus_as = 1'b0;
      tick();
      check_out({tag, ".end"}, 8'h00, 1'b0, 1'b0);
      if (ovl && !undef) m_boot--;
    end
    tick();
    check_out({tag, ".idle"}, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] t;
    bit rd;
    int ab;
    logic [7:0] rcs;
    int rws;
    bit run, rovl;

    tick();
    tick();
    check_out("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("post_reset", 8'h00, 1'b0, 1'b0);

    // overlay: writes pass through, aborted reads keep the boot count
    bus_cycle(8'h01, 1'b0, 0, 0);
    bus_cycle(8'h00, 1'b1, 2, 0);
    bus_cycle(8'h02, 1'b1, 0, 1);
    for (int i = 0; i < 3; i++) bus_cycle(8'h00, 1'b1, 0, 0);
    bus_cycle(8'h00, 1'b1, 0, 0);

    // region boundaries after the overlay has expired
    bus_cycle(8'h80, 1'b1, 0, 0);
    bus_cycle(8'hBF, 1'b1, 0, 0);
    bus_cycle(8'hC0, 1'b1, 0, 0);
    bus_cycle(8'hFF, 1'b1, 0, 0);
    bus_cycle(8'h3C, 1'b1, 0, 0);
    bus_cycle(8'h7F, 1'b1, 0, 0);
    bus_cycle(8'h40, 1'b0, 0, 0);
    bus_cycle(8'h04, 1'b1, 0, 1);
    bus_cycle(8'h3B, 1'b1, 0, 0);
    bus_cycle(8'h03, 1'b1, 2, 0);
    bus_cycle(8'h03, 1'b1, 0, 0);

    // reset while acknowledging a RAM1 access
    bus_as = 1'b1; bus_rw = 1'b1; bus_addr = 8'h80;
    tick();
    tick();
    check_out("ack80", 8'h08, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("rst_in_ack", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; bus_as = 1'b0;
    m_boot = BOOT;
    tick();
    check_out("rst_release", 8'h00, 1'b0, 1'b0);
    bus_cycle(8'h00, 1'b1, 0, 0);

    // random cycles, occasionally aborted
    for (int i = 0; i < 80; i++) begin
      t  = 8'($urandom);
      rd = 1'($urandom);
      model(t, rd, m_boot, rcs, rws, run, rovl);
      ab = 0;
      if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, run ? BT : 1 + rws);
      bus_cycle(t, rd, ab, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
